lcd_nibble_if: RTL



---
 rtl/lcd_nibble_if_if.sv | 13 +
 rtl/lcd_nibble_if.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lcd_nibble_if_if.sv
// rtl/lcd_nibble_if_if.sv - processor-side write handshake for the LCD nibble engine
// The core drives the write strobe and byte, the engine returns busy and the sticky overflow flag.
interface lcd_nibble_if_if;
   logic       wr_i;
   logic       rs_i;
   logic [7:0] data_i;
   logic       nib_i;
   logic       busy_o;
   logic       ovf_o;

   modport master (output wr_i, rs_i, data_i, nib_i, input busy_o, ovf_o);
   modport slave  (input wr_i, rs_i, data_i, nib_i, output busy_o, ovf_o);
endinterface

// File: rtl/lcd_nibble_if.sv
// rtl/lcd_nibble_if.sv - byte-to-nibble transmit engine for an HD44780-class 4-bit LCD bus
// One write produces RS/data setup, E pulse and hold per nibble, then an execution wait.
module lcd_nibble_if #(
   parameter int T_SU  = 8,
   parameter int T_E   = 48,
   parameter int T_H   = 8,
   parameter int T_GAP = 100,
   parameter int T_CMD = 4000,
   parameter int T_CLR = 160000,
   parameter int CW    = 18
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   lcd_nibble_if_if.slave  host,
   output logic            lcd_rs_o,
   output logic [3:0]      lcd_data_o,
   output logic            lcd_e_o
);

   typedef enum logic [3:0] {
      IDLE, SU_HI, E_HI, H_HI, GAP, SU_LO, E_LO, H_LO, WAIT
   } state_t;

   localparam logic [CW-1:0] L_SU  = CW'(T_SU - 1);
   localparam logic [CW-1:0] L_E   = CW'(T_E - 1);
   localparam logic [CW-1:0] L_H   = CW'(T_H - 1);
   localparam logic [CW-1:0] L_GAP = CW'(T_GAP - 1);
   localparam logic [CW-1:0] L_CMD = CW'(T_CMD - 1);
   localparam logic [CW-1:0] L_CLR = CW'(T_CLR - 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          rs_q;
   logic [7:0]    data_q;
   logic          nib_q;
   logic          busy_q;
   logic          ovf_q;
   logic          lcd_rs_q;
   logic [3:0]    lcd_data_q;
   logic          lcd_e_q;
   logic          slow_d;

   // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
   assign slow_d = nib_q | (~rs_q & (data_q[7:2] == 6'd0));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rs_q       <= 1'b0;
         data_q     <= 8'h00;
         nib_q      <= 1'b0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
         lcd_rs_q   <= 1'b0;
         lcd_data_q <= 4'h0;
         lcd_e_q    <= 1'b0;
      end else begin
         if (host.wr_i && busy_q) begin
            ovf_q <= 1'b1;
         end
         if (state_q == IDLE) begin
            if (host.wr_i) begin
               rs_q       <= host.rs_i;
               data_q     <= host.data_i;
               nib_q      <= host.nib_i;
               lcd_rs_q   <= host.rs_i;
               lcd_data_q <= host.data_i[7:4];
               busy_q     <= 1'b1;
               cnt_q      <= L_SU;
               state_q    <= SU_HI;
            end
         end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
         end else begin
            case (state_q)
               SU_HI: begin
                  state_q <= E_HI;
                  cnt_q   <= L_E;
                  lcd_e_q <= 1'b1;
               end
               E_HI: begin
                  state_q <= H_HI;
                  cnt_q   <= L_H;
                  lcd_e_q <= 1'b0;
               end
               H_HI: begin
                  if (nib_q) begin
                     state_q    <= WAIT;
                     cnt_q      <= L_CLR;
                     lcd_data_q <= data_q[3:0];
                  end else begin
                     state_q <= GAP;
                     cnt_q   <= L_GAP;
                  end
               end
               GAP: begin
                  state_q    <= SU_LO;
                  cnt_q      <= L_SU;
                  lcd_data_q <= data_q[3:0];
               end
               SU_LO: begin
                  state_q <= E_LO;
                  cnt_q   <= L_E;
                  lcd_e_q <= 1'b1;
               end
               E_LO: begin
                  state_q <= H_LO;
                  cnt_q   <= L_H;
                  lcd_e_q <= 1'b0;
               end
               H_LO: begin
                  state_q <= WAIT;
                  cnt_q   <= slow_d ? L_CLR : L_CMD;
               end
               WAIT: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  lcd_e_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign host.busy_o = busy_q;
   assign host.ovf_o  = ovf_q;
   assign lcd_rs_o    = lcd_rs_q;
   assign lcd_data_o  = lcd_data_q;
   assign lcd_e_o     = lcd_e_q;

endmodule
